// File: rtl/keypad_scanner.sv
// Column-strobed key matrix scanner with per-key scan-count debounce and a one-entry event register.
// Define KEYPAD_RELEASE_EVENTS_EN to emit release events; otherwise releases update key_state silently.
module keypad_scanner #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_SCANS  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  output logic [COLS-1:0]                 col_drive_n,
  input  logic [ROWS-1:0]                 row_in_n,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            key_pressed,
  output logic [ROWS*COLS-1:0]            key_state
);

  localparam int KEYS = ROWS * COLS;
  localparam int KW   = $clog2(KEYS);
  localparam int CW   = $clog2(STABLE_SCANS) + 1;
  localparam int SW   = $clog2(SETTLE_CYCLES);
  localparam int CLW  = $clog2(COLS);

  typedef enum logic {
    SETTLE,
    SAMPLE
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [CLW-1:0]    col_q, col_d;
  logic [COLS-1:0]   col_drive_n_q, col_drive_n_d;

  logic [ROWS-1:0]   sync1_q, sync2_q;
  logic [ROWS-1:0]   raw;

  logic [CW-1:0]     cnt_q [KEYS];
  logic [CW-1:0]     cnt_d [KEYS];
  logic [KEYS-1:0]   key_state_q, key_state_d;
  logic              key_valid_q, key_valid_d;
  logic [KW-1:0]     key_code_q, key_code_d;
  logic              key_pressed_q, key_pressed_d;
  logic              slot_free;

  // Two-flop synchroniser; idle rows are high, so flops reset to ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= row_in_n;
      sync2_q <= sync1_q;
    end
  end

  assign raw = ~sync2_q;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q         <= SETTLE;
      settle_q      <= '0;
      col_q         <= '0;
      col_drive_n_q <= ~(COLS'(1));
    end else begin
      fsm_q         <= fsm_d;
      settle_q      <= settle_d;
      col_q         <= col_d;
      col_drive_n_q <= col_drive_n_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d    = fsm_q;
    settle_d = settle_q;
    col_d    = col_q;
    case (fsm_q)
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          fsm_d    = SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        fsm_d = SETTLE;
        col_d = (col_q == CLW'(COLS - 1)) ? '0 : col_q + CLW'(1);
      end
      default: fsm_d = SETTLE;
    endcase
  end

  assign slot_free = !key_valid_q || key_ready;

  // Output / debounce logic, evaluated for the current column during SAMPLE
  always_comb begin
    logic [KW-1:0] k;
    logic          toggled;
    col_drive_n_d = ~(COLS'(1) << col_d);
    cnt_d         = cnt_q;
    key_state_d   = key_state_q;
    key_valid_d   = key_valid_q && !key_ready;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    k             = '0;
    toggled       = 1'b0;
    if (fsm_q == SAMPLE) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        k = KW'(r * COLS) + KW'(col_q);
        if (raw[r] == key_state_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] < CW'(STABLE_SCANS - 1)) begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end else begin
`ifndef KEYPAD_RELEASE_EVENTS_EN
          // Silent releases bypass the slot and the one-toggle-per-sample limit.
          if (key_state_q[k]) begin
            key_state_d[k] = 1'b0;
            cnt_d[k]       = '0;
          end else
`endif
          if (!toggled && slot_free) begin
            toggled        = 1'b1;
            key_state_d[k] = ~key_state_q[k];
            cnt_d[k]       = '0;
            key_valid_d    = 1'b1;
            key_code_d     = k;
            key_pressed_d  = ~key_state_q[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < KEYS; i++) begin
        cnt_q[i] <= '0;
      end
      key_state_q   <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      key_state_q   <= key_state_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign col_drive_n = col_drive_n_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;
  assign key_state   = key_state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner at default parameters with a behavioural 4x4 key matrix.
// Release-event expectations follow KEYPAD_RELEASE_EVENTS_EN.
module tb_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  col_drive_n;
  logic [3:0]  row_in_n;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic [15:0] key_state;

  logic [15:0] keys_held;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          n_hi;
  int          unstable;

  keypad_scanner #(
    .ROWS(4),
    .COLS(4),
    .SETTLE_CYCLES(4),
    .STABLE_SCANS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .col_drive_n(col_drive_n),
    .row_in_n(row_in_n),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_code(key_code),
    .key_pressed(key_pressed),
    .key_state(key_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A closed key pulls its row low only while its column is driven.
  always_comb begin
    row_in_n = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_held[r*4+c] && !col_drive_n[c]) row_in_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wait_valid(input int limit);
    while (!key_valid && cyc < limit) tick();
  endtask

  task automatic do_reset(input logic [15:0] held, input logic ready);
    keys_held = held;
    key_ready = ready;
    reset     = 1'b1;
    repeat (2) @(negedge clock);
    reset     = 1'b0;
    cyc       = 0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    key_ready = 1'b1;
    keys_held = '0;
    cyc       = 0;

    // Key 6 held from reset, ready high
    do_reset(16'h0040, 1'b1);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_pressed", key_pressed, 0);
    check("rst_state", key_state, 0);
    check("col_c0", col_drive_n, 4'b1110);
    run_to(5);
    check("col_c1", col_drive_n, 4'b1101);
    run_to(10);
    check("col_c2", col_drive_n, 4'b1011);
    run_to(15);
    check("col_c3", col_drive_n, 4'b0111);
    run_to(20);
    check("col_wrap", col_drive_n, 4'b1110);
    wait_valid(300);
    check("k6_event_cycle", cyc, 75);
    check("k6_code", key_code, 6);
    check("k6_pressed", key_pressed, 1);
    check("k6_state", key_state, 16'h0040);
    n_hi = 0;
    repeat (100) begin
      tick();
      if (key_valid) n_hi++;
    end
    check("k6_single_event", n_hi, 0);
    check("k6_state_hold", key_state, 16'h0040);

    // Bounce of 3 samples on key 6
    do_reset(16'h0040, 1'b1);
    run_to(60);
    keys_held = '0;
    n_hi = 0;
    while (cyc < 200) begin
      tick();
      if (key_valid) n_hi++;
    end
    check("bounce_no_event", n_hi, 0);
    check("bounce_state", key_state, 0);

    // Keys 2 and 6 together with ready low, then a one-cycle ready pulse
    do_reset(16'h0044, 1'b0);
    wait_valid(300);
    check("dual_first_cycle", cyc, 75);
    check("dual_first_code", key_code, 2);
    check("dual_first_state", key_state, 16'h0004);
    unstable = 0;
    while (cyc < 175) begin
      tick();
      if (key_valid !== 1'b1 || key_code !== 4'd2 || key_pressed !== 1'b1 ||
          key_state !== 16'h0004) unstable++;
    end
    check("dual_hold_stable", unstable, 0);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("dual_accept_clears", key_valid, 0);
    wait_valid(400);
    check("dual_second_cycle", cyc, 195);
    check("dual_second_code", key_code, 6);
    check("dual_second_pressed", key_pressed, 1);
    check("dual_second_state", key_state, 16'h0044);

    // Key 15 press then release
    do_reset(16'h8000, 1'b1);
    wait_valid(300);
    check("k15_press_cycle", cyc, 80);
    check("k15_press_code", key_code, 15);
    check("k15_press_pressed", key_pressed, 1);
    run_to(90);
    keys_held = '0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    wait_valid(400);
    check("k15_release_cycle", cyc, 160);
    check("k15_release_code", key_code, 15);
    check("k15_release_pressed", key_pressed, 0);
    check("k15_release_state", key_state, 0);
`else
    n_hi = 0;
    while (cyc < 159) begin
      tick();
      if (key_valid) n_hi++;
    end
    check("k15_pre_release_state", key_state, 16'h8000);
    tick();
    if (key_valid) n_hi++;
    check("k15_release_state", key_state, 0);
    repeat (40) begin
      tick();
      if (key_valid) n_hi++;
    end
    check("k15_no_release_event", n_hi, 0);
`endif

    // Reset in column-3 SETTLE with an event pending
    do_reset(16'h0040, 1'b0);
    wait_valid(300);
    check("pend_cycle", cyc, 75);
    run_to(76);
    reset = 1'b1;
    #1;
    check("midrst_valid", key_valid, 0);
    check("midrst_col", col_drive_n, 4'b1110);
    check("midrst_state", key_state, 0);
    @(negedge clock);
    reset = 1'b0;
    cyc   = 0;
    wait_valid(300);
    check("redebounce_cycle", cyc, 75);
    check("redebounce_code", key_code, 6);

    // Accept and load on the same edge
    do_reset(16'h0044, 1'b0);
    wait_valid(300);
    check("b2b_first_code", key_code, 2);
    run_to(194);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("b2b_valid_kept", key_valid, 1);
    check("b2b_code", key_code, 6);
    check("b2b_pressed", key_pressed, 1);
    check("b2b_state", key_state, 16'h0044);
    tick();
    check("b2b_hold", key_code, 6);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("b2b_drained", key_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
